// File: rtl/dmem_pkg.sv
// Data-memory responder shared definitions.
// MMIO address map and STATUS bit positions.
package dmem_pkg;

  localparam logic [31:0] MMIO_BASE     = 32'h8000_0000;
  localparam logic [31:0] TX_DATA_ADDR  = MMIO_BASE + 32'h0;
  localparam logic [31:0] STATUS_ADDR   = MMIO_BASE + 32'h4;
  localparam logic [31:0] CYCLE_LO_ADDR = MMIO_BASE + 32'h8;
  localparam logic [31:0] CYCLE_HI_ADDR = MMIO_BASE + 32'hC;

  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_CNT_LO = 4;

endpackage

// File: rtl/tx_fifo.sv
// Byte-wide TX FIFO for the data-memory responder.
// Push while full is accepted only with a same-cycle pop.
module tx_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [7:0]                    din,
  input  logic                          pop,
  output logic [7:0]                    dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(FIFO_DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = cnt;
  assign dout    = empty ? 8'h00 : mem[rp];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; empty masks stale data on dout.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory slave: word RAM with byte lanes, TX FIFO, STATUS, cycle counter.
// Define DMEM_CYCLE_CNT_EN to build the 64-bit cycle counter.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 16384,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_web,
  output logic [31:0] dm_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] widx;
  logic          in_ram;
  logic          sel_tx;
  logic          sel_st;
  logic          sel_lo;
  logic          sel_hi;
  logic          tx_wr;
  logic          st_clr;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          ovf;
  logic [31:0]   status;
  logic [63:0]   cyc;

  assign widx   = dm_addr[AW+1:2];
  assign in_ram = (dm_addr >> (AW + 2)) == 32'd0;
  assign sel_tx = dm_addr == TX_DATA_ADDR;
  assign sel_st = dm_addr == STATUS_ADDR;
  assign sel_lo = dm_addr == CYCLE_LO_ADDR;
  assign sel_hi = dm_addr == CYCLE_HI_ADDR;
  assign tx_wr  = sel_tx && dm_web[0];
  assign st_clr = sel_st && dm_web[0] && dm_wdata[ST_OVF];

  tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_wr),
    .din   (dm_wdata[7:0]),
    .pop   (tx_ready),
    .dout  (tx_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign tx_valid = !empty;

  // Byte-lane RAM writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (in_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (dm_web[i]) mem[widx][8*i +: 8] <= dm_wdata[8*i +: 8];
      end
    end
  end

  // Sticky overflow: set on a dropped push, cleared by STATUS write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (tx_wr && full && !tx_ready) begin
      ovf <= 1'b1;
    end else if (st_clr) begin
      ovf <= 1'b0;
    end
  end

`ifdef DMEM_CYCLE_CNT_EN
  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst) cyc <= '0;
    else      cyc <= cyc + 64'd1;
  end
`else
  assign cyc = '0;
`endif

  // STATUS register image.
  always_comb begin
    status                 = '0;
    status[ST_FULL]        = full;
    status[ST_EMPTY]       = empty;
    status[ST_OVF]         = ovf;
    status[ST_CNT_LO +: 4] = 4'(count);
  end

  // Combinational read mux; TX_DATA and unmapped read 0.
  always_comb begin
    dm_rdata = '0;
    unique case (1'b1)
      in_ram:  dm_rdata = mem[widx];
      sel_st:  dm_rdata = status;
      sel_lo:  dm_rdata = cyc[31:0];
      sel_hi:  dm_rdata = cyc[63:32];
      default: dm_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder.
// Reference model: byte queue, associative RAM, counters.
module tb_data_mem_responder;

  localparam int DEPTH = 16384;
  localparam int FD    = 8;
  localparam logic [31:0] TXA = 32'h8000_0000;
  localparam logic [31:0] STA = 32'h8000_0004;
  localparam logic [31:0] LOA = 32'h8000_0008;
  localparam logic [31:0] HIA = 32'h8000_000C;

  logic        clk;
  logic        rst;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_web;
  logic [31:0] dm_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  data_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_web   (dm_web),
    .dm_rdata (dm_rdata),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        vld;
    string       nm;
  } exp_t;

  exp_t        rd_q[$];
  logic [7:0]  sb_tx[$];
  logic [7:0]  mq[$];
  logic [31:0] ram[int];
  bit          ovf;
  longint unsigned cyc;
  bit          model_ok;
  int          n_cmp;
  int          n_bad;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int sz;
    sz = mq.size();
    if (a < DEPTH * 4) return ram[int'(a >> 2)];
    if (a == STA)
      return 32'((sz % 16) * 16 + (ovf ? 4 : 0) +
                 (sz == 0 ? 2 : 0) + (sz == FD ? 1 : 0));
`ifdef DMEM_CYCLE_CNT_EN
    if (a == LOA) return cyc[31:0];
    if (a == HIA) return cyc[63:32];
`endif
    return 32'h0;
  endfunction

  task automatic model_update(input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] we, input logic rdy,
                              input logic r);
    bit popped;
    if (a < DEPTH * 4) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) ram[int'(a >> 2)][8*i +: 8] = wd[8*i +: 8];
    end
    if (!r) begin
      mq.delete();
      sb_tx.delete();
      ovf = 0;
      cyc = 0;
      model_ok = 1;
      return;
    end
    cyc = cyc + 1;
    popped = 0;
    if (mq.size() > 0 && rdy) begin
      void'(mq.pop_front());
      popped = 1;
    end
    if (a == TXA && we[0]) begin
      if (mq.size() < FD) begin
        mq.push_back(wd[7:0]);
        sb_tx.push_back(wd[7:0]);
      end else begin
        ovf = 1;
      end
    end
    if (a == STA && we[0] && wd[2]) ovf = 0;
    if (popped && a == TXA && we[0] && mq.size() > FD) $display("model error");
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] we, input logic rdy,
                      input logic r, input string nm);
    exp_t e;
    dm_addr  = a;
    dm_wdata = wd;
    dm_web   = we;
    tx_ready = rdy;
    rst      = r;
    if (model_ok) begin
      e.rd  = model_read(a);
      e.vld = mq.size() != 0;
      e.nm  = nm;
      rd_q.push_back(e);
    end
    @(posedge clk);
    model_update(a, wd, we, rdy, r);
    #1;
  endtask

  // Monitor: read data / valid scoreboard and TX byte stream.
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] b;
    if (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      n_cmp++;
      if (dm_rdata !== e.rd) begin
        n_bad++;
        $display("FAIL %s rdata: got %h want %h", e.nm, dm_rdata, e.rd);
      end
      n_cmp++;
      if (tx_valid !== e.vld) begin
        n_bad++;
        $display("FAIL %s tx_valid: got %b want %b", e.nm, tx_valid, e.vld);
      end
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      n_cmp++;
      if (sb_tx.size() == 0) begin
        n_bad++;
        $display("FAIL tx_underflow: got %h want none", tx_data);
      end else begin
        b = sb_tx.pop_front();
        if (tx_data !== b) begin
          n_bad++;
          $display("FAIL tx_data: got %h want %h", tx_data, b);
        end
      end
    end
  end

  logic [31:0] a;
  logic [31:0] unm [4];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_ok = 0;
    ovf = 0;
    cyc = 0;
    unm[0] = 32'h0001_0000;
    unm[1] = 32'h8000_0010;
    unm[2] = 32'h7FFF_0000;
    unm[3] = 32'h8000_0001;

    step(0, 0, 0, 0, 0, "rst0");
    step(0, 0, 0, 0, 0, "rst1");
    step(LOA, 0, 0, 0, 1, "cyc_rel");
    step(LOA, 0, 0, 0, 1, "cyc_lo1");
    step(HIA, 0, 0, 0, 1, "cyc_hi");
    step(STA, 0, 0, 0, 1, "status_rst");

    for (int i = 0; i < 32; i++)
      step(32'(i * 4), $urandom, 4'hF, 0, 1, "ram_init");
    step(32'h100, 0, 4'hF, 0, 1, "init100");
    step(32'hF000, 32'h1234_5678, 4'hF, 0, 1, "initF000");

    step(32'h100, 32'hDEAD_BEEF, 4'hF, 0, 1, "ram_wr_old");
    step(32'h100, 32'h0000_5500, 4'b0010, 0, 1, "ram_lane_old");
    step(32'h102, 0, 0, 0, 1, "ram_lane_rd");

    step(TXA, 32'h41, 4'h1, 0, 1, "push_a");
    step(TXA, 32'h42, 4'h1, 0, 1, "push_b");
    step(TXA, 32'h43, 4'h1, 0, 1, "push_c");
    step(STA, 0, 0, 0, 1, "status_3");
    for (int i = 0; i < 4; i++) step(STA, 0, 0, 1, 1, "drain");

    for (int i = 0; i < FD + 1; i++)
      step(TXA, 32'(8'h60 + i), 4'h1, 0, 1, "fill");
    step(STA, 0, 0, 0, 1, "status_ovf");
    step(STA, 32'h4, 4'h1, 0, 1, "clr_ovf");
    step(STA, 0, 0, 0, 1, "status_clr");
    step(TXA, 32'h7A, 4'h1, 1, 1, "push_full_pop");
    step(STA, 0, 0, 0, 1, "status_full");
    for (int i = 0; i < FD + 1; i++) step(STA, 0, 0, 1, 1, "drain2");

    for (int i = 0; i < 5; i++)
      step(TXA, 32'(8'h30 + i), 4'h1, 0, 1, "q5");
    step(STA, 0, 0, 1, 0, "mid_rst");
    step(STA, 0, 0, 1, 1, "status_after_rst");
    step(32'h100, 0, 0, 0, 1, "ram_after_rst");

    step(32'h7FFF_0000, 32'hFFFF_FFFF, 4'hF, 0, 1, "unm_wr");
    step(32'h8000_0010, 0, 0, 0, 1, "unm_rd");
    step(32'hF000, 0, 0, 0, 1, "alias_chk");
    step(32'h0001_0000, 0, 0, 0, 1, "ram_bound");

    for (int n = 0; n < 3000; n++) begin
      int k;
      k = int'($urandom_range(0, 9));
      case (k)
        0, 1, 2, 3: a = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
        4, 5:       a = TXA;
        6:          a = STA;
        7:          a = LOA;
        8:          a = HIA;
        default:    a = unm[$urandom_range(0, 3)];
      endcase
      step(a, $urandom, 4'($urandom), 1'($urandom_range(0, 2) == 0),
           $urandom_range(0, 299) != 0, "rand");
    end

    for (int i = 0; i < 12; i++) step(STA, 0, 0, 1, 1, "final");
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
